adder_subtractor: RTL and testbench
===================================

Name: adder_subtractor

Overview:
- Registered N-bit two's-complement adder/subtractor. Computes x+y (s=0) or x−y (s=1) with carry-out and signed-overflow flags.
- One-cycle latency, with a valid strobe tracking the result.
- Used as a generic arithmetic leaf inside datapaths. The arithmetic core is a structural ripple-carry chain of full adders; y is conditioned by XOR with s, and s drives the carry-in.

Parameters:
- N, 4, operand and result width in bits (N ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/mode valid this cycle; result captured on this edge.
- x  input  N  operand A (two's complement or unsigned).
- y  input  N  operand B.
- s  input  1  mode: 0 = add, 1 = subtract (x − y).
- f  output  N  registered result, modulo 2^N.
- cout  output  1  registered carry out of the MSB stage.
- ov  output  1  registered signed-overflow flag.
- out_valid  output  1  registered; high the cycle after in_valid was sampled high.

Behaviour:
- Reset: asynchronous assert of rst_n=0 forces f=0, cout=0, ov=0, out_valid=0 immediately. Release is synchronous to the next clk edge, with no further effect.
- Core (combinational):
  - yc[i] = y[i] XOR s.
  - c[0] = s.
  - sum[i] = x[i]^yc[i]^c[i].
  - c[i+1] = majority(x[i], yc[i], c[i]), for i = 0..N−1.
- Flags:
  - cout_c = c[N].
  - ov_c = c[N] XOR c[N−1].
  - Subtract: cout=1 means no borrow (x ≥ y unsigned); cout=0 means borrow.
- Register stage, on each rising clk with rst_n=1:
  - out_valid ← in_valid.
  - If in_valid=1: f ← sum, cout ← cout_c, ov ← ov_c.
  - If in_valid=0: f/cout/ov hold their previous values.
- Latency: exactly 1 cycle from in_valid sample to out_valid/result. Full throughput (a new operation every cycle). No backpressure.
- Wrap-around: the result is always modulo 2^N, with no saturation (unless the optional feature is compiled in).
  - Example, N=4: 15+1 → f=0, cout=1, ov=0.
  - Example, N=4: 7+1 → f=8, cout=0, ov=1.
- Subtract by zero: x−0 → f=x, cout=1, ov=0.
- Most-negative operand, N=4: 0−8 → f=8, cout=0, ov=1.
- Reset mid-operation: a pending result is discarded and out_valid=0 until the next in_valid.
- No X propagation from s or operands when in_valid=0 (registers not loaded).

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined: when ov_c=1, the registered f is clamped to the signed extreme:
  - if x[N−1]=0 → f = 0111…1 (max positive);
  - if x[N−1]=1 → f = 1000…0 (min negative).
  - cout and ov are still reported unchanged (ov=1).
- Undefined: f always takes the wrapped sum. The saturation logic is absent.

Test Plan:
- Reset: rst_n=0 asynchronously with no clock edge → f=0, cout=0, ov=0, out_valid=0 immediately.
- x=6, y=7, s=1, in_valid=1 → next cycle: f=15 (−1), cout=0, ov=0, out_valid=1.
- x=6, y=7, s=0 → f=13, cout=0, ov=1. With ADDSUB_SATURATE_EN: f=7, ov=1.
- x=3, y=4, s=0 → f=7, cout=0, ov=0. Then s=1 → f=15, cout=0, ov=0.
- Wrap/borrow: x=15, y=1, s=0 → f=0, cout=1, ov=0. Then x=5, y=5, s=1 → f=0, cout=1, ov=0.
- Hold/valid:
  - Drive in_valid=0 with changing x/y → f unchanged, out_valid=0.
  - Back-to-back in_valid=1 with random x, y, s over 200 cycles → each result matches (x ± y) mod 16, with flags per the formulas.

Source files
------------

// File: rtl/adder_subtractor.sv
// adder_subtractor: registered N-bit two's-complement add/subtract with
// carry-out and signed-overflow flags, one-cycle latency, valid tracking.
// Optional build macro ADDSUB_SATURATE_EN clamps f to the signed extreme
// on overflow; without it the result always wraps modulo 2^N.

// Single full-adder cell; the arithmetic core is a ripple chain of these.
module adder_subtractor_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (a & ci) | (b & ci);
endmodule

module adder_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         s,
    output logic [N-1:0] f,
    output logic         cout,
    output logic         ov,
    output logic         out_valid
);
    localparam int STAGES = 1;

    logic [N-1:0]    yc;
    logic [N-1:0]    sum_c;
    logic [N:0]      c;
    logic            cout_c;
    logic            ov_c;
    logic [N-1:0]    f_nxt;
    logic [STAGES:0] vld_pipe;

    // Subtract is x + ~y + 1: invert y with s and feed s in as the carry.
    assign yc   = y ^ {N{s}};
    assign c[0] = s;

    adder_subtractor_fa u_fa [N-1:0] (
        .a   (x),
        .b   (yc),
        .ci  (c[N-1:0]),
        .sum (sum_c),
        .co  (c[N:1])
    );

    // Carry out of the MSB; overflow when carries into and out of it differ.
    assign cout_c = c[N];
    assign ov_c   = c[N] ^ c[N-1];

`ifdef ADDSUB_SATURATE_EN
    // On overflow clamp toward the sign of x (the sign the true result has).
    always_comb begin
        f_nxt = sum_c;
        if (ov_c)
            f_nxt = x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`else
    // Plain wrap-around result.
    always_comb begin
        f_nxt = sum_c;
    end
`endif

    assign vld_pipe[0] = in_valid;
    assign out_valid   = vld_pipe[STAGES];

    // Valid strobe follows in_valid by one cycle; reset drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe[STAGES:1] <= '0;
        else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // Result registers load only on in_valid so idle operands never leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f    <= '0;
            cout <= 1'b0;
            ov   <= 1'b0;
        end else if (in_valid) begin
            f    <= f_nxt;
            cout <= cout_c;
            ov   <= ov_c;
        end
    end
endmodule

// File: tb/tb_adder_subtractor.sv
// Directed + random self-check of adder_subtractor at N=4.
module tb_adder_subtractor;
    localparam int N = 4;
`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] x, y;
    logic         s;
    logic [N-1:0] f;
    logic         cout, ov, out_valid;

    int nvec = 0;
    int nerr = 0;

    adder_subtractor #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .s(s),
        .f(f), .cout(cout), .ov(ov), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ef, input logic ec,
                           input logic eo, input logic ev);
        chk({tag, ".f"}, 32'(f), 32'(ef));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ov"}, 32'(ov), 32'(eo));
        chk({tag, ".vld"}, 32'(out_valid), 32'(ev));
    endtask

    // Drive one valid op at the falling edge, sample 1 time unit after capture.
    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic m);
        @(negedge clk);
        x = a; y = b; s = m; in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference built from integer math, not from the carry chain.
    function automatic logic [5:0] model(input int a, input int b, input bit m);
        int r, sa, sb, sr;
        logic [3:0] ff;
        logic cc, oo;
        r  = m ? a - b : a + b;
        cc = m ? (a >= b) : (a + b > 15);
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        sr = m ? sa - sb : sa + sb;
        oo = (sr > 7) || (sr < -8);
        ff = 4'(r & 15);
        if (SAT && oo) ff = (sa < 0) ? 4'd8 : 4'd7;
        return {oo, cc, ff};
    endfunction

    initial begin
        logic [5:0] e;
        logic [3:0] ra, rb;
        logic       rm;

        // Asynchronous reset, checked before the first clock edge.
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; s = 1'b0;
        #2;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op(4'd6, 4'd7, 1'b1);  chk_all("6-7", 4'd15, 1'b0, 1'b0, 1'b1);
        op(4'd6, 4'd7, 1'b0);  chk_all("6+7", SAT ? 4'd7 : 4'd13, 1'b0, 1'b1, 1'b1);
        op(4'd3, 4'd4, 1'b0);  chk_all("3+4", 4'd7, 1'b0, 1'b0, 1'b1);
        op(4'd3, 4'd4, 1'b1);  chk_all("3-4", 4'd15, 1'b0, 1'b0, 1'b1);
        op(4'd15, 4'd1, 1'b0); chk_all("15+1", 4'd0, 1'b1, 1'b0, 1'b1);
        op(4'd5, 4'd5, 1'b1);  chk_all("5-5", 4'd0, 1'b1, 1'b0, 1'b1);
        op(4'd7, 4'd1, 1'b0);  chk_all("7+1", SAT ? 4'd7 : 4'd8, 1'b0, 1'b1, 1'b1);
        op(4'd0, 4'd8, 1'b1);  chk_all("0-8", SAT ? 4'd7 : 4'd8, 1'b0, 1'b1, 1'b1);
        op(4'd8, 4'd1, 1'b1);  chk_all("-8-1", SAT ? 4'd8 : 4'd7, 1'b1, 1'b1, 1'b1);
        op(4'd9, 4'd0, 1'b1);  chk_all("9-0", 4'd9, 1'b1, 1'b0, 1'b1);

        // Idle cycles: changing and unknown operands must not disturb results.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0; x = 4'(i + 2); y = 4'(3 * i); s = i[0];
            @(posedge clk);
            #1;
            chk_all("hold", 4'd9, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0; x = 'x; y = 'x; s = 1'bx;
        @(posedge clk);
        #1;
        chk_all("holdx", 4'd9, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a pending operation.
        op(4'd3, 4'd2, 1'b0);  chk_all("3+2", 4'd5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        x = 4'd1; y = 4'd1; s = 1'b0; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midrst", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("postrst", 4'd0, 1'b0, 1'b0, 1'b0);

        // Back-to-back random traffic.
        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            op(ra, rb, rm);
            e = model(int'(ra), int'(rb), rm);
            chk_all($sformatf("rnd%0d", i), e[3:0], e[4], e[5], 1'b1);
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain.vld", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
